// File: rtl/x1_subcpu_mailbox.sv
// Byte mailbox between the X1 host I/O port and the mr16 sub-CPU: command FIFO in, response holding register out.
// Optional sticky overrun flags in status bits 7:6 are compiled in with `define MBOX_OVERRUN_EN.
module x1_subcpu_mailbox #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_HCS,
  input  logic        I_HWR,
  input  logic        I_HRD,
  input  logic        I_HA,
  input  logic [7:0]  I_HD,
  output logic [7:0]  O_HD,
  output logic [15:0] O_CMD,
  input  logic        I_POP,
  input  logic [15:0] I_RSP,
  output logic        O_INT,
  input  logic        I_ACK
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  pop_q;
  logic                  tgl_q;
  logic                  rsp_valid;
  logic [7:0]            rsp_data;
  logic                  int_pend;
  logic                  ovr_h;
  logic                  ovr_r;

  logic        empty;
  logic        full;
  logic        host_wr_data;
  logic        host_rd_data;
  logic        host_rd_stat;
  logic        pop_edge;
  logic        do_pop;
  logic        do_push;
  logic        capture;
  logic [31:0] count_ext;
  logic [3:0]  cmd_count;
  logic [7:0]  head_data;

  assign empty        = (count == '0);
  assign full         = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign host_wr_data = I_HCS & I_HWR & ~I_HA;
  assign host_rd_data = I_HCS & I_HRD & ~I_HA;
  assign host_rd_stat = I_HCS & I_HRD & I_HA;
  assign pop_edge     = I_POP & ~pop_q;
  assign do_pop       = pop_edge & ~empty;
  // A coincident pop frees a slot, so a push into a full FIFO is still accepted.
  assign do_push      = host_wr_data & (~full | do_pop);
  assign capture      = (I_RSP[8] != tgl_q);

  assign count_ext = 32'(count);
  assign cmd_count = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign head_data = empty ? 8'h00 : mem[rd_ptr];
  assign O_CMD     = {empty, 3'b000, cmd_count, head_data};
  assign O_INT     = int_pend;

  wire unused_rsp_bits = &{1'b0, I_RSP[15:9]};

  always_ff @(posedge I_CLK) begin
    if (do_push) mem[wr_ptr] <= I_HD;
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_q     <= 1'b0;
      tgl_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      int_pend  <= 1'b0;
      O_HD      <= 8'h00;
    end else begin
      pop_q <= I_POP;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (do_push && empty) int_pend <= 1'b1;
      else if (I_ACK)       int_pend <= 1'b0;

      if (host_rd_data)      O_HD <= rsp_data;
      else if (host_rd_stat) O_HD <= {ovr_h, ovr_r, 3'b000, ~empty, rsp_valid, full};

      // A new response arriving alongside a host read keeps rsp_valid set.
      if (capture) begin
        rsp_data  <= I_RSP[7:0];
        rsp_valid <= 1'b1;
        tgl_q     <= I_RSP[8];
      end else if (host_rd_data) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MBOX_OVERRUN_EN
  logic host_wr_stat;
  assign host_wr_stat = I_HCS & I_HWR & I_HA;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      ovr_h <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      if (host_wr_data && !do_push) ovr_h <= 1'b1;
      else if (host_wr_stat)        ovr_h <= 1'b0;
      if (capture && rsp_valid)     ovr_r <= 1'b1;
      else if (host_wr_stat)        ovr_r <= 1'b0;
    end
  end
`else
  assign ovr_h = 1'b0;
  assign ovr_r = 1'b0;
`endif

endmodule

// File: tb/tb_x1_subcpu_mailbox.sv
// Directed bench for x1_subcpu_mailbox; expected overrun bits follow `define MBOX_OVERRUN_EN.
module tb_x1_subcpu_mailbox;

`ifdef MBOX_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_HCS;
  logic        I_HWR;
  logic        I_HRD;
  logic        I_HA;
  logic [7:0]  I_HD;
  logic [7:0]  O_HD;
  logic [15:0] O_CMD;
  logic        I_POP;
  logic [15:0] I_RSP;
  logic        O_INT;
  logic        I_ACK;

  int checks = 0;
  int fails  = 0;

  x1_subcpu_mailbox #(.DEPTH_LOG2(3)) dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .I_HCS   (I_HCS),
    .I_HWR   (I_HWR),
    .I_HRD   (I_HRD),
    .I_HA    (I_HA),
    .I_HD    (I_HD),
    .O_HD    (O_HD),
    .O_CMD   (O_CMD),
    .I_POP   (I_POP),
    .I_RSP   (I_RSP),
    .O_INT   (O_INT),
    .I_ACK   (I_ACK)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic host_write(input logic a, input logic [7:0] d);
    I_HCS = 1'b1; I_HWR = 1'b1; I_HA = a; I_HD = d;
    applyStimulus(1);
    I_HCS = 1'b0; I_HWR = 1'b0; I_HA = 1'b0;
  endtask

  task automatic host_read(input logic a);
    I_HCS = 1'b1; I_HRD = 1'b1; I_HA = a;
    applyStimulus(1);
    I_HCS = 1'b0; I_HRD = 1'b0; I_HA = 1'b0;
  endtask

  task automatic pop_pulse(input int high_cycles);
    I_POP = 1'b1;
    applyStimulus(high_cycles);
    I_POP = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    I_RESET = 1'b1; I_HCS = 1'b0; I_HWR = 1'b0; I_HRD = 1'b0; I_HA = 1'b0;
    I_HD = 8'h00; I_POP = 1'b0; I_RSP = 16'h0000; I_ACK = 1'b0;
    applyStimulus(2);
    I_RESET = 1'b0;
    applyStimulus(1);

    checkOutput("reset_hd",   {8'h00, O_HD}, 16'h0000);
    checkOutput("reset_cmd",  O_CMD, 16'h8000);
    checkOutput("reset_int",  {15'h0, O_INT}, 16'h0000);
    host_read(1'b1);
    checkOutput("reset_status", {8'h00, O_HD}, 16'h0000);

    host_write(1'b0, 8'h41);
    checkOutput("push_cmd", O_CMD, 16'h0141);
    checkOutput("push_int", {15'h0, O_INT}, 16'h0001);
    I_ACK = 1'b1;
    applyStimulus(1);
    I_ACK = 1'b0;
    checkOutput("ack_int", {15'h0, O_INT}, 16'h0000);

    pop_pulse(1);
    checkOutput("pop_to_empty", O_CMD, 16'h8000);

    for (int i = 1; i <= 8; i++) host_write(1'b0, 8'(i));
    checkOutput("fill_int", {15'h0, O_INT}, 16'h0001);
    I_ACK = 1'b1;
    applyStimulus(1);
    I_ACK = 1'b0;
    checkOutput("full_cmd", O_CMD, 16'h0801);
    host_write(1'b0, 8'hFF);
    checkOutput("drop_cmd", O_CMD, 16'h0801);
    host_read(1'b1);
    checkOutput("full_status", {8'h00, O_HD}, {8'h00, OVR, 7'h05});

    pop_pulse(5);
    checkOutput("long_pop", O_CMD, 16'h0702);
    for (int i = 0; i < 4; i++) pop_pulse(1);
    checkOutput("count3", O_CMD, 16'h0306);

    I_HCS = 1'b1; I_HWR = 1'b1; I_HA = 1'b0; I_HD = 8'hAA; I_POP = 1'b1;
    applyStimulus(1);
    I_HCS = 1'b0; I_HWR = 1'b0; I_POP = 1'b0;
    applyStimulus(1);
    checkOutput("push_pop_cmd", O_CMD, 16'h0307);
    checkOutput("push_pop_int", {15'h0, O_INT}, 16'h0000);

    I_RSP = 16'h015A;
    applyStimulus(1);
    host_read(1'b1);
    checkOutput("rsp_status", {8'h00, O_HD}, {8'h00, OVR, 7'h06});
    host_read(1'b0);
    checkOutput("rsp_data", {8'h00, O_HD}, 16'h005A);
    host_read(1'b1);
    checkOutput("rsp_cleared", {8'h00, O_HD}, {8'h00, OVR, 7'h04});
    applyStimulus(3);
    host_read(1'b1);
    checkOutput("rsp_no_recapture", {8'h00, O_HD}, {8'h00, OVR, 7'h04});

    I_RSP = 16'h0000;
    applyStimulus(1);
    host_read(1'b0);
    checkOutput("rsp_zero", {8'h00, O_HD}, 16'h0000);

    I_RSP = 16'h0111;
    applyStimulus(1);
    I_RSP = 16'h0022;
    applyStimulus(1);
    host_read(1'b1);
    checkOutput("ovr_status", {8'h00, O_HD}, {8'h00, OVR, OVR, 6'h06});
    host_read(1'b0);
    checkOutput("ovr_data", {8'h00, O_HD}, 16'h0022);
    host_write(1'b1, 8'h00);
    host_read(1'b1);
    checkOutput("ovr_cleared", {8'h00, O_HD}, 16'h0004);
    host_read(1'b0);
    checkOutput("stale_read", {8'h00, O_HD}, 16'h0022);
    checkOutput("final_cmd", O_CMD, 16'h0307);

    I_RESET = 1'b1;
    #2;
    checkOutput("mid_reset_cmd", O_CMD, 16'h8000);
    I_RESET = 1'b0;
    applyStimulus(1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
